// File: rtl/op0_inverso.sv
// op0_inverso: recovers Y from C = X*(Y+1) by bit-serial restoring division C / X
module op0_inverso (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] C,
  input  logic [3:0] X,
  output logic       busy,
  output logic       done,
  output logic [3:0] Y,
  output logic [1:0] err
);
  typedef enum logic [1:0] {IDLE, DIV, CHECK, DONE} state_t;
  state_t state;
  logic [7:0] c_sh;
  logic [3:0] x_r;
  logic [4:0] rem;
  logic [7:0] q;
  logic [2:0] cnt;
  logic [4:0] t;
  logic [4:0] diff;
  logic       ge;
  // one restoring-division step: trial subtract of the divisor from the shifted remainder
  always_comb begin
    t = {rem[3:0], c_sh[7]};
    diff = t - {1'b0, x_r};
    ge = t >= {1'b0, x_r};
  end
  // control FSM with datapath and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      c_sh <= '0;
      x_r <= '0;
      rem <= '0;
      q <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      Y <= '0;
      err <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          c_sh <= C;
          x_r <= X;
          rem <= '0;
          q <= '0;
          cnt <= 3'd7;
          busy <= 1'b1;
          state <= DIV;
        end
        DIV: begin
          c_sh <= {c_sh[6:0], 1'b0};
          rem <= ge ? diff : t;
          q <= {q[6:0], ge};
          cnt <= cnt - 3'd1;
          if (cnt == 3'd0) state <= CHECK;
        end
        CHECK: begin
          err <= (x_r == 4'd0) ? 2'b01 :
                 (rem != 5'd0) ? 2'b10 :
                 (q == 8'd0 || q > 8'd16) ? 2'b11 : 2'b00;
          Y <= (x_r != 4'd0 && rem == 5'd0 && q != 8'd0 && q <= 8'd16) ? q[3:0] - 4'd1 : 4'd0;
          done <= 1'b1;
          state <= DONE;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_op0_inverso.sv
// tb_op0_inverso: directed and exhaustive checks of op0_inverso
module tb_op0_inverso;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] C = '0;
  logic [3:0] X = '0;
  logic busy, done;
  logic [3:0] Y;
  logic [1:0] err;
  int tests = 0;
  int failed = 0;

  op0_inverso dut (
    .clk(clk), .rst_n(rst_n), .start(start), .C(C), .X(X),
    .busy(busy), .done(done), .Y(Y), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] ref_model(input logic [7:0] c, input logic [3:0] x);
    int qq;
    if (x == 0) return {2'b01, 4'd0};
    if (c % x != 0) return {2'b10, 4'd0};
    qq = c / x;
    if (qq == 0 || qq > 16) return {2'b11, 4'd0};
    return {2'b00, 4'(qq - 1)};
  endfunction

  // start one operation; report latency to done, done pulse width and the results
  task automatic run(input logic [7:0] c, input logic [3:0] x, output logic [31:0] obs);
    int lat, pw;
    logic [3:0] y;
    logic [1:0] e;
    @(negedge clk);
    C = c; X = x; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; C = ~c; X = ~x;
    lat = 0; pw = 0;
    while (!done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    y = Y; e = err;
    while (done && pw < 5) begin
      pw++;
      @(posedge clk); #1;
    end
    obs = {8'(lat), 8'(pw), 10'd0, e, y};
  endtask

  function automatic logic [31:0] expw(input logic [5:0] r);
    return {8'd9, 8'd1, 10'd0, r};
  endfunction

  logic [7:0] vc [7] = '{8'd18, 8'd240, 8'd1, 8'd17, 8'h2A, 8'd18, 8'd0};
  logic [3:0] vx [7] = '{4'd3, 4'd15, 4'd1, 4'd1, 4'd0, 4'd4, 4'd5};
  logic [5:0] ve [7] = '{{2'b00, 4'd5}, {2'b00, 4'd15}, {2'b00, 4'd0}, {2'b11, 4'd0},
                         {2'b01, 4'd0}, {2'b10, 4'd0}, {2'b11, 4'd0}};

  initial begin
    logic [31:0] obs;
    int nd, d1, d2;
    logic [3:0] y1;
    logic [1:0] e1;
    int exh_fail;
    #12;
    chk("reset", {busy, done, Y, err}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run(vc[i], vx[i], obs);
      chk($sformatf("dir%0d", i), obs, expw(ve[i]));
      if (i == 0) chk("op0", 32'(8'(4'd3 + obs[3:0] * 4'd3)), 32'd18);
    end
    exh_fail = failed;
    for (int x = 1; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        run(8'(x * (y + 1)), 4'(x), obs);
        chk($sformatf("fwd x%0d y%0d", x, y), obs, expw({2'b00, 4'(y)}));
      end
    for (int x = 0; x < 16; x++)
      for (int c = 0; c < 256; c++) begin
        run(8'(c), 4'(x), obs);
        chk($sformatf("all c%0d x%0d", c, x), obs, expw(ref_model(8'(c), 4'(x))));
      end
    if (failed != exh_fail) $display("exhaustive sweep had %0d bad results", failed - exh_fail);
    // start pulsed while busy must be ignored
    @(negedge clk);
    C = 8'd18; X = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0; d1 = 0; y1 = '0; e1 = '0;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        if (nd == 1) begin d1 = n; y1 = Y; e1 = err; end
      end
      if (n == 5) chk("busy_mid", busy, 1'b1);
      start = (n == 2);
      if (n == 2) begin C = 8'd18; X = 4'd4; end
    end
    chk("ign_cnt", nd, 1);
    chk("ign_lat", d1, 9);
    chk("ign_res", {e1, y1}, {2'b00, 4'd5});
    chk("idle_busy", busy, 1'b0);
    // start held high: back-to-back operations
    @(negedge clk);
    C = 8'd240; X = 4'd15; start = 1'b1;
    @(posedge clk); #1;
    nd = 0; d1 = 0; d2 = 0;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        if (nd == 1) d1 = n;
        if (nd == 2) d2 = n;
        chk($sformatf("held_res%0d", nd), {err, Y}, {2'b00, 4'd15});
      end
    end
    start = 1'b0;
    chk("held_cnt", nd, 2);
    chk("held_lat", d1, 9);
    chk("held_gap", (d2 - d1 == 10) || (d2 - d1 == 11), 1'b1);
    for (int n = 0; n < 15 && busy; n++) @(posedge clk);
    #1;
    chk("held_idle", busy, 1'b0);
    // asynchronous reset mid-division
    run(8'd18, 4'd3, obs);
    chk("pre_rst", obs, expw({2'b00, 4'd5}));
    @(negedge clk);
    C = 8'd18; X = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {busy, done, Y, err}, 8'd0);
    #3;
    rst_n = 1'b1;
    nd = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    chk("rst_nodone", nd, 0);
    run(8'd240, 4'd15, obs);
    chk("post_rst", obs, expw({2'b00, 4'd15}));
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
